// File: rtl/stopwatch_sec_stage.sv
// Seconds stage: one-second prescaler, BCD 00-59 count, start/stop/clear FSM,
// set/select preload, min_tick pulse on 59->00. Ports: clk, reset, controls in; digits, min_tick, running out.
module stopwatch_sec_stage #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       set,
  input  logic       select,
  input  logic [3:0] set_ones,
  input  logic [3:0] set_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic       min_tick,
  output logic       running
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;

  logic       do_clr;
  logic       do_ld;
  logic       do_stop;
  logic       do_start;
  logic       do_cnt;
  logic       do_hold;
  logic [3:0] ld_ones;
  logic [3:0] ld_tens;

  // Exclusive action decode; stop also masks start and the count edge.
  always_comb begin
    do_clr   = clear;
    do_ld    = !clear && set && select;
    do_stop  = !clear && !(set && select) && stop;
    do_start = !clear && !(set && select) && !stop
               && start && (state != RUN);
    do_cnt   = !clear && !(set && select) && !stop
               && (state == RUN);
    do_hold  = !(do_clr || do_ld || do_stop
                 || do_start || do_cnt);
    ld_ones  = (set_ones > 4'd9) ? 4'd9 : set_ones;
    ld_tens  = (set_tens > 4'd5) ? 4'd5 : set_tens;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_tick <= 1'b0;
    end else begin
      min_tick <= 1'b0;
      unique case (1'b1)
        do_clr: begin
          state    <= IDLE;
          presc    <= '0;
          sec_ones <= 4'd0;
          sec_tens <= 4'd0;
        end
        do_ld: begin
          presc    <= '0;
          sec_ones <= ld_ones;
          sec_tens <= ld_tens;
          // Leave IDLE so the loaded digits are kept.
          if (state == IDLE) state <= PAUSE;
        end
        do_stop: begin
          if (state == RUN) state <= PAUSE;
        end
        do_start: begin
          state <= RUN;
        end
        do_cnt: begin
          if (presc == LAST) begin
            presc <= '0;
            if (sec_ones != 4'd9) begin
              sec_ones <= sec_ones + 4'd1;
            end else begin
              sec_ones <= 4'd0;
              if (sec_tens != 4'd5) begin
                sec_tens <= sec_tens + 4'd1;
              end else begin
                sec_tens <= 4'd0;
                min_tick <= 1'b1;
              end
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        do_hold: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign running = (state == RUN);

endmodule

// File: doc/stopwatch_sec_stage.md
# stopwatch_sec_stage

Seconds stage of the stopwatch datapath, directly upstream of the first-minute digit counter. It divides the system clock into a one-second tick and counts seconds as two BCD digits, 00–59. A start/stop/clear control FSM gates the count, and a set/select path preloads the digits. On each 59→00 rollover it emits a one-cycle `min_tick` pulse, which the minute counter consumes as its advance event.

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per second tick; must be ≥ 2.
- `clk` input 1: system clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: level; requests counting.
- `stop` input 1: level; requests pause.
- `clear` input 1: level; returns to 00 and idle.
- `set` input 1: load strobe; acts only together with `select`.
- `select` input 1: qualifies `set` for this stage.
- `set_ones` input 4: BCD seconds-ones load value.
- `set_tens` input 4: BCD seconds-tens load value.
- `sec_ones` output 4: seconds ones digit, 0–9.
- `sec_tens` output 4: seconds tens digit, 0–5.
- `min_tick` output 1: registered one-cycle pulse on each 59→00 rollover.
- `running` output 1: high while the FSM is in RUN.

## Operation
- FSM states are IDLE, RUN and PAUSE.
  - IDLE: digits 00, prescaler 0.
  - RUN: prescaler counts.
  - PAUSE: prescaler and digits hold.
- Per-cycle priority, highest first: `reset` > `clear` > (`set` & `select`) > `stop` > `start`.
- `reset` or `clear`: state goes to IDLE, digits to 00, prescaler to 0, `min_tick` to 0.
- `set` & `select`:
  - `sec_ones` loads min(`set_ones`, 9) and `sec_tens` loads min(`set_tens`, 5).
  - Prescaler goes to 0 and `min_tick` to 0.
  - From IDLE, state goes to PAUSE so the loaded value is retained.
  - From RUN or PAUSE, state is unchanged.
- `set` without `select`: ignored.
- `stop` in RUN goes to PAUSE. `stop` in IDLE or PAUSE does nothing.
- `start` in IDLE or PAUSE goes to RUN. `start` in RUN does nothing.
- `start` and `stop` asserted together: `stop` wins. From RUN the state goes to PAUSE; otherwise it is unchanged.
- Prescaler in RUN: counts 0..`TICK_DIV`−1. When it reaches `TICK_DIV`−1, it wraps to 0 and the seconds advance by one on the same edge.
- Seconds advance:
  - Ones digit < 9: ones +1.
  - Ones digit = 9: ones goes to 0. Then tens +1 if tens < 5; otherwise tens goes to 0 and `min_tick` is 1 for that cycle.
- `min_tick` is 0 in every cycle that is not a rollover cycle.
- Prescaler width is ceil(log2(`TICK_DIV`)). All digit arithmetic is 4-bit BCD, and no digit ever holds a value outside its range.
- `running` = (state == RUN), decoded from the state register.

## Timing
- Reset values: `sec_ones` = 0, `sec_tens` = 0, `min_tick` = 0, `running` = 0, state IDLE, prescaler 0.
- `start` sampled high at edge N:
  - `running` is 1 after edge N.
  - The prescaler is 1 after edge N+1.
  - The first second increment is visible after edge N+`TICK_DIV`.
- `stop` at edge N: `running` is 0 after edge N and the prescaler value is frozen. A later `start` resumes from the frozen prescaler value; the partial second is not lost.
- `min_tick` is high for exactly the one cycle in which the digits first read 00 after 59. The downstream minute counter samples it on the next edge.
- Load and clear take effect on the sampling edge, with latency 1.
- A `clear` or `reset` on the same edge as a rollover suppresses `min_tick`.
- A `set`/`select` load on the same edge as a rollover suppresses `min_tick` and the advance.
- All outputs are driven directly from registers; there are no combinational input→output paths.

## Test plan
- Reset behaviour, `TICK_DIV` = 4: assert `reset` 2 cycles, then `start` → `running` = 1; `sec_ones` steps 0→1→2 every 4 cycles.
- Rollover: load 58 via `set` & `select`, then `start` → 59 after 4 cycles, then 00 with `min_tick` = 1 for exactly 1 cycle; `min_tick` is 0 on the next cycle and the count continues from 00.
- Pause mid-second: `start`, wait 2 cycles, `stop` for 10 cycles, then `start` → the next increment occurs 2 cycles after the restart edge, and the digits are unchanged during the pause.
- Clamping and ignored load:
  - Load `set_ones` = 12, `set_tens` = 7 → reads 59, state PAUSE.
  - `set` without `select` → digits unchanged.
- Priority:
  - `start` & `stop` together in RUN → PAUSE.
  - `clear` & `set` & `select` together → 00, IDLE.
  - `clear` on the rollover edge at 59 → 00, `min_tick` stays 0.
- Reset mid-run: at 37 with the prescaler at 3, assert `reset` → next cycle reads 00, `running` = 0, `min_tick` = 0, and there are no further increments without `start`.
